// File: rtl/uart_hex_loader.sv
// ASCII-hex to memory loader: packs nibbles MSB-first into words; rx_clr in the accept cycle, mem_we one cycle later.
// The echo waits out tx_busy, and no new byte is accepted until the echo is issued, so the UART holds rdy meanwhile.
module uart_hex_loader #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ECHO   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_en,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_clr,
  input  logic              i_tx_busy,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_wr,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_full,
  output logic              o_err
);
  localparam int NIBS  = WORD_W / 4;
  localparam int CNT_W = $clog2(NIBS + 1);
  localparam logic [CNT_W-1:0] NIB_LAST = CNT_W'(NIBS - 1);
  localparam logic [ADDR_W:0]  WC_LAST  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_ECHO} state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_byte;
  logic [WORD_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_nib_cnt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_word_count;
  logic                r_full, r_err;

  logic                w_is_hex, w_is_ws, w_is_clr;
  logic                w_accept, w_we, w_tx_wr;
  logic [3:0]          w_nib;
  logic [WORD_W-1:0]   w_new_shift;

  always_comb begin
    w_is_hex = 1'b1;
    w_nib    = r_byte[3:0];
    if (r_byte >= 8'h30 && r_byte <= 8'h39) begin
      w_nib = r_byte[3:0];
    end else if ((r_byte >= 8'h41 && r_byte <= 8'h46) || (r_byte >= 8'h61 && r_byte <= 8'h66)) begin
      w_nib = r_byte[3:0] + 4'd9;
    end else begin
      w_is_hex = 1'b0;
    end
  end

  assign w_is_ws     = (r_byte == 8'h0A) || (r_byte == 8'h0D) || (r_byte == 8'h20);
  assign w_is_clr    = (r_byte == 8'h78) || (r_byte == 8'h58);
  assign w_new_shift = {r_shift[WORD_W-5:0], w_nib};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Acceptance is gated by reset so rx_clr stays low while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_we        = 1'b0;
    w_tx_wr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_rst && i_load_en && i_rx_valid && !i_tx_busy) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PROC;
        end
      end
      S_PROC: begin
        w_we        = w_is_hex && !r_full && (r_nib_cnt == NIB_LAST);
        w_state_nxt = (ECHO != 0) ? S_ECHO : S_IDLE;
      end
      S_ECHO: begin
        if (!i_tx_busy) begin
          w_tx_wr     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byte       <= '0;
      r_shift      <= '0;
      r_nib_cnt    <= '0;
      r_ptr        <= '0;
      r_word_count <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_byte <= i_rx_data;
    end else if (r_state == S_PROC) begin
      if (w_is_hex) begin
        if (r_full) begin
          r_err <= 1'b1;
        end else if (r_nib_cnt == NIB_LAST) begin
          r_shift      <= w_new_shift;
          r_nib_cnt    <= '0;
          r_word_count <= r_word_count + (ADDR_W + 1)'(1);
          // Pointer parks on the last slot once the memory is full.
          if (r_word_count == WC_LAST) r_full <= 1'b1;
          else                         r_ptr  <= r_ptr + ADDR_W'(1);
        end else begin
          r_shift   <= w_new_shift;
          r_nib_cnt <= r_nib_cnt + CNT_W'(1);
        end
      end else if (w_is_ws) begin
        if (r_nib_cnt != '0) begin
          r_err     <= 1'b1;
          r_nib_cnt <= '0;
          r_shift   <= '0;
        end
      end else if (w_is_clr) begin
        r_ptr        <= '0;
        r_word_count <= '0;
        r_full       <= 1'b0;
        r_err        <= 1'b0;
        r_nib_cnt    <= '0;
        r_shift      <= '0;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_rx_clr     = w_accept;
  assign o_mem_we     = w_we;
  assign o_mem_addr   = r_ptr;
  assign o_mem_wdata  = w_we ? w_new_shift : '0;
  assign o_tx_wr      = w_tx_wr;
  assign o_tx_data    = (ECHO != 0) ? r_byte : 8'h00;
  assign o_word_count = r_word_count;
  assign o_full       = r_full;
  assign o_err        = r_err;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Bench for uart_hex_loader: directed scenarios plus randomized hex streams checked against a byte-level model.
module tb_uart_hex_loader;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              clk, rst, load_en, rx_valid, tx_busy;
  logic [7:0]        rx_data, tx_data;
  logic              rx_clr, tx_wr, mem_we, full, err;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [AW:0]       word_count;

  int checks = 0;
  int errors = 0;
  bit rand_busy = 0;

  uart_hex_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(AW), .ECHO(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_clr(rx_clr), .i_tx_busy(tx_busy), .o_tx_data(tx_data), .o_tx_wr(tx_wr),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_word_count(word_count), .o_full(full), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed traffic
  logic [AW-1:0]     got_addr[$];
  logic [WORD_W-1:0] got_data[$];
  logic [7:0]        got_echo[$];
  int cyc = 0, last_clr = -100, lat_bad = 0, overlap = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (rx_clr) last_clr = cyc;
      if (mem_we) begin
        got_addr.push_back(mem_addr);
        got_data.push_back(mem_wdata);
        if (cyc - last_clr != 1) lat_bad++;
      end
      if (tx_wr) begin
        got_echo.push_back(tx_data);
        if (cyc - last_clr < 2) lat_bad++;
        if (mem_we) overlap++;
      end
    end
  end

  // Reference model: text-level view of the loader
  int                m_wc, m_dig;
  logic [WORD_W-1:0] m_acc;
  bit                m_err;
  int                exp_addr[$];
  logic [WORD_W-1:0] exp_data[$];
  logic [7:0]        exp_echo[$];

  function automatic int hex_val(input logic [7:0] b);
    string digits = "0123456789abcdef";
    logic [7:0] c = b;
    if (c >= 8'h41 && c <= 8'h5A) c = c + 8'd32;
    for (int i = 0; i < 16; i++) if (digits[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [7:0] hex_char(input int n, input bit upper);
    string digits = "0123456789abcdef";
    logic [7:0] c = digits[n];
    if (upper && c >= 8'h61) c = c - 8'd32;
    return c;
  endfunction

  task automatic model_reset();
    m_wc = 0; m_dig = 0; m_acc = '0; m_err = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int v = hex_val(b);
    exp_echo.push_back(b);
    if (v >= 0) begin
      if (m_wc == DEPTH) m_err = 1;
      else begin
        m_acc = m_acc * 16 + v;
        m_dig++;
        if (m_dig == WORD_W / 4) begin
          exp_addr.push_back(m_wc);
          exp_data.push_back(m_acc);
          m_wc++; m_dig = 0; m_acc = '0;
        end
      end
    end else if (b == 8'h0A || b == 8'h0D || b == 8'h20) begin
      if (m_dig != 0) begin m_err = 1; m_dig = 0; m_acc = '0; end
    end else if (b == 8'h78 || b == 8'h58) begin
      model_reset();
    end else begin
      m_err = 1;
    end
  endtask

  task automatic clr_q();
    got_addr.delete(); got_data.delete(); got_echo.delete();
    exp_addr.delete(); exp_data.delete(); exp_echo.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offers one byte until the DUT accepts it; returns one tick after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    rx_data = b; rx_valid = 1'b1;
    for (int n = 0; n < 300 && !got; n++) begin
      if (rand_busy) tx_busy = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      got = rx_clr;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0; tx_busy = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL accept_timeout: byte %h got no rx_clr, required within 300 cycles", b); end
    else model_byte(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    drain(6);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b1; rx_valid = 1'b1; rx_data = 8'h35; tx_busy = 1'b0;
    model_reset(); clr_q();
    @(negedge clk);
    checks++;
    if ({rx_clr, tx_wr, mem_we, full, err} !== 5'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_pulses: clr/wr/we/full/err=%b tx_data=%h, required 00000 and 00", {rx_clr, tx_wr, mem_we, full, err}, tx_data);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h wc=%0d, required all zero", mem_addr, mem_wdata, word_count);
    end
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    drain(2);
  endtask

  task automatic test_deadbeef();
    string s = "DEADBEEF";
    bit ok;
    clr_q();
    send_str(s);
    checks++;
    if (got_data.size() != 1 || got_addr[0] !== 0 || got_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL deadbeef_write: n=%0d addr=%0d data=%h, required n=1 addr=0 data=deadbeef", got_data.size(), got_addr[0], got_data[0]);
    end
    ok = (got_echo.size() == 8);
    for (int i = 0; i < 8 && ok; i++) ok = (got_echo[i] === s[i]);
    checks++;
    if (!ok) begin errors++; $display("FAIL deadbeef_echo: %0d echoes not matching, required 8 bytes DEADBEEF", got_echo.size()); end
    checks++;
    if (word_count !== 3'd1 || err !== 1'b0) begin
      errors++; $display("FAIL deadbeef_status: wc=%0d err=%b, required wc=1 err=0", word_count, err);
    end
  endtask

  task automatic test_lowercase();
    clr_q();
    send_str("0000001a");
    checks++;
    if (got_data.size() != 1 || got_addr[0] !== 1 || got_data[0] !== 32'h0000001A) begin
      errors++; $display("FAIL lower_write: n=%0d addr=%0d data=%h, required n=1 addr=1 data=0000001a", got_data.size(), got_addr[0], got_data[0]);
    end
    checks++;
    if (word_count !== 3'd2) begin errors++; $display("FAIL lower_wc: got %0d required 2", word_count); end
  endtask

  task automatic test_err_clear();
    clr_q();
    send_str("12\n");
    checks++;
    if (got_data.size() != 0 || err !== 1'b1) begin
      errors++; $display("FAIL partial_err: writes=%0d err=%b, required writes=0 err=1", got_data.size(), err);
    end
    send_str("x");
    checks++;
    if (err !== 1'b0 || word_count !== 3'd0 || full !== 1'b0) begin
      errors++; $display("FAIL x_clear: err=%b wc=%0d full=%b, required 0 0 0", err, word_count, full);
    end
    clr_q();
    send_str("CAFEF00D");
    checks++;
    if (got_data.size() != 1 || got_addr[0] !== 0 || got_data[0] !== 32'hCAFEF00D || word_count !== 3'd1 || err !== 1'b0) begin
      errors++; $display("FAIL after_x_write: n=%0d addr=%0d data=%h wc=%0d err=%b, required 1 0 cafef00d 1 0",
                         got_data.size(), got_addr[0], got_data[0], word_count, err);
    end
  endtask

  task automatic test_full();
    logic [WORD_W-1:0] wv[DEPTH];
    bit ok;
    send_str("x");
    clr_q();
    for (int w = 0; w < DEPTH; w++) begin
      wv[w] = $urandom();
      for (int k = WORD_W / 4 - 1; k >= 0; k--) send_byte(hex_char(int'(wv[w][k*4 +: 4]), 1'($urandom_range(0, 1))));
    end
    send_str("7");
    ok = (got_data.size() == DEPTH);
    for (int w = 0; w < DEPTH && ok; w++) ok = (got_addr[w] === w[AW-1:0]) && (got_data[w] === wv[w]);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_writes: %0d writes or wrong addr/data, required %0d sequential", got_data.size(), DEPTH); end
    checks++;
    if (full !== 1'b1 || word_count !== 3'd4 || err !== 1'b1 || mem_addr !== 2'd3) begin
      errors++; $display("FAIL full_status: full=%b wc=%0d err=%b addr=%0d, required 1 4 1 3", full, word_count, err, mem_addr);
    end
    checks++;
    if (got_echo.size() != 33 || got_echo[32] !== 8'h37) begin
      errors++; $display("FAIL full_echo: n=%0d last=%h, required n=33 last=37", got_echo.size(), got_echo[got_echo.size()-1]);
    end
  endtask

  task automatic test_busy_hold();
    int n_clr = 0, n_wr = 0;
    send_str("x");
    clr_q();
    rx_data = 8'h35; rx_valid = 1'b1; tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_clr !== 1'b1) begin errors++; $display("FAIL busy_accept: rx_clr=%b required 1", rx_clr); end
    @(posedge clk); #1;
    model_byte(8'h35);
    rx_data = 8'h36; tx_busy = 1'b1;
    repeat (100) begin
      @(negedge clk);
      n_clr += int'(rx_clr); n_wr += int'(tx_wr);
      @(posedge clk); #1;
    end
    checks++;
    if (n_clr != 0 || n_wr != 0) begin
      errors++; $display("FAIL busy_hold: rx_clr=%0d tx_wr=%0d during busy, required 0 0", n_clr, n_wr);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_wr !== 1'b1 || rx_clr !== 1'b0 || tx_data !== 8'h35) begin
      errors++; $display("FAIL busy_release: tx_wr=%b rx_clr=%b tx_data=%h, required 1 0 35", tx_wr, rx_clr, tx_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rx_clr !== 1'b1) begin errors++; $display("FAIL busy_next_accept: rx_clr=%b required 1", rx_clr); end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    model_byte(8'h36);
    drain(6);
    checks++;
    if (got_echo.size() != 2 || got_echo[1] !== 8'h36) begin
      errors++; $display("FAIL busy_echo: n=%0d second=%h, required 2 36", got_echo.size(), got_echo[1]);
    end
  endtask

  task automatic test_load_en();
    int n_clr = 0, n_wr = 0;
    send_str("x");
    clr_q();
    load_en = 1'b0; rx_data = 8'h33; rx_valid = 1'b1;
    repeat (20) begin @(negedge clk); n_clr += int'(rx_clr); @(posedge clk); #1; end
    checks++;
    if (n_clr != 0) begin errors++; $display("FAIL load_dis: rx_clr=%0d while disabled, required 0", n_clr); end
    load_en = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_clr !== 1'b1) begin errors++; $display("FAIL load_accept: rx_clr=%b required 1", rx_clr); end
    @(posedge clk); #1;
    model_byte(8'h33);
    load_en = 1'b0; rx_data = 8'h34;
    n_clr = 0;
    repeat (20) begin @(negedge clk); n_clr += int'(rx_clr); n_wr += int'(tx_wr); @(posedge clk); #1; end
    checks++;
    if (n_clr != 0 || n_wr != 1 || got_echo.size() != 1 || got_echo[0] !== 8'h33) begin
      errors++; $display("FAIL load_fall: rx_clr=%0d tx_wr=%0d echo=%h, required 0 1 33", n_clr, n_wr, got_echo[0]);
    end
    rx_valid = 1'b0; load_en = 1'b1;
    drain(2);
  endtask

  task automatic test_reset_midword();
    send_str("x");
    send_str("0123ABCD");
    send_str("g");
    checks++;
    if (err !== 1'b1 || word_count !== 3'd1) begin
      errors++; $display("FAIL junk_err: err=%b wc=%0d, required 1 1", err, word_count);
    end
    for (int i = 1; i <= 5; i++) send_byte(hex_char(i, 1'b0));
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rx_clr, tx_wr, mem_we, full, err} !== 5'b0 || tx_data !== 8'h00 || mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
      errors++; $display("FAIL midword_reset: clr/wr/we/full/err=%b tx=%h addr=%0d wdata=%h wc=%0d, required all zero",
                         {rx_clr, tx_wr, mem_we, full, err}, tx_data, mem_addr, mem_wdata, word_count);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    clr_q();
    send_str("89ABCDEF");
    checks++;
    if (got_data.size() != 1 || got_addr[0] !== 0 || got_data[0] !== 32'h89ABCDEF || word_count !== 3'd1) begin
      errors++; $display("FAIL post_reset_write: n=%0d addr=%0d data=%h wc=%0d, required 1 0 89abcdef 1",
                         got_data.size(), got_addr[0], got_data[0], word_count);
    end
  endtask

  task automatic test_random();
    logic [7:0]        bq[$];
    logic [WORD_W-1:0] v;
    int nw, kind;
    bit ok;
    rand_busy = 1;
    for (int r = 0; r < 8; r++) begin
      clr_q(); bq.delete();
      bq.push_back(($urandom_range(0, 1) == 0) ? 8'h78 : 8'h58);
      nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) begin
        kind = $urandom_range(0, 7);
        if (kind == 0) begin
          for (int k = 0; k < $urandom_range(1, 7); k++) bq.push_back(hex_char($urandom_range(0, 15), 1'b0));
          bq.push_back(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
        end else if (kind == 1) begin
          bq.push_back(($urandom_range(0, 1) == 0) ? 8'h67 : 8'h23);
        end
        v = $urandom();
        for (int k = WORD_W / 4 - 1; k >= 0; k--) bq.push_back(hex_char(int'(v[k*4 +: 4]), 1'($urandom_range(0, 1))));
        if ($urandom_range(0, 2) == 0) bq.push_back(8'h20);
      end
      foreach (bq[i]) send_byte(bq[i]);
      drain(8);
      ok = (got_data.size() == exp_data.size());
      for (int i = 0; i < exp_data.size() && ok; i++) ok = (got_addr[i] === exp_addr[i][AW-1:0]) && (got_data[i] === exp_data[i]);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_writes: round %0d got %0d writes, required %0d matching", r, got_data.size(), exp_data.size()); end
      ok = (got_echo.size() == exp_echo.size());
      for (int i = 0; i < exp_echo.size() && ok; i++) ok = (got_echo[i] === exp_echo[i]);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_echo: round %0d got %0d echoes, required %0d matching", r, got_echo.size(), exp_echo.size()); end
      checks++;
      if (word_count !== m_wc[AW:0] || full !== (m_wc == DEPTH) || err !== m_err) begin
        errors++; $display("FAIL rand_status: round %0d wc=%0d full=%b err=%b, required %0d %b %b",
                           r, word_count, full, err, m_wc, (m_wc == DEPTH), m_err);
      end
    end
    rand_busy = 0;
    checks++;
    if (lat_bad != 0 || overlap != 0) begin
      errors++; $display("FAIL timing: latency violations=%0d we/wr overlaps=%0d, required 0 0", lat_bad, overlap);
    end
  endtask

  initial begin
    test_reset();
    test_deadbeef();
    test_lowercase();
    test_err_clear();
    test_full();
    test_busy_hold();
    test_load_en();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
